// File: rtl/fc_ctrl.sv
// Fully-connected layer sequencer: streams inputs/weights to the MAC and writes each neuron result to e0~e4.
// Optional FC_CYCLE_CNT_EN adds a 20-bit pass cycle counter output fc_cycle_cnt.
module fc_ctrl #(
    parameter int unsigned WEIGHT_ADDR_WIDTH = 15,
    parameter int unsigned IN_ADDR_NUM       = 20,
    parameter int unsigned OUT_NUM           = 120,
    parameter int unsigned MAC_LATENCY       = 3,
    parameter int unsigned WEIGHT_BASE       = 0
) (
    input  logic                         clk,
    input  logic                         srstn,
    input  logic                         fc_start,
    input  logic                         mem_sel,
    output logic [9:0]                   sram_raddr_c,
    output logic [9:0]                   sram_raddr_d,
    output logic [WEIGHT_ADDR_WIDTH-1:0] sram_raddr_weight,
    output logic                         data_sel,
    output logic                         mac_clear,
    output logic                         mac_en,
    input  logic [7:0]                   fc_result,
    output logic                         sram_write_enable_e0,
    output logic                         sram_write_enable_e1,
    output logic                         sram_write_enable_e2,
    output logic                         sram_write_enable_e3,
    output logic                         sram_write_enable_e4,
    output logic [3:0]                   sram_bytemask_e,
    output logic [9:0]                   sram_waddr_e,
    output logic [7:0]                   sram_wdata_e,
    output logic                         busy,
    output logic                         fc_done
`ifdef FC_CYCLE_CNT_EN
    ,
    output logic [19:0]                  fc_cycle_cnt
`endif
);

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned I_W    = 10;
    localparam int unsigned O_W    = 9;
    localparam logic [I_W-1:0] I_LAST = I_W'(IN_ADDR_NUM - 1);
    localparam logic [O_W-1:0] O_LAST = O_W'(OUT_NUM - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [I_W-1:0] i_cnt, i_nxt;
    logic [O_W-1:0] o_cnt, o_nxt;
    logic [WEIGHT_ADDR_WIDTH-1:0] w_nxt;
    logic           sel_nxt;
    logic [ADDR_W-1:0] raddr_c_nxt, raddr_d_nxt;
    logic           mac_en_nxt, mac_clear_nxt;
    logic           start_acc, issue, last_issue, tag_in;

    // Last-element tag and neuron index delayed until the neuron's result is valid
    logic           tag_sr [MAC_LATENCY];
    logic [O_W-1:0] o_sr   [MAC_LATENCY];
    logic [O_W-1:0] wo;
    logic [2:0]     wr_bank;

    logic [4:0]        we_q, we_nxt;
    logic [3:0]        mask_nxt;
    logic [ADDR_W-1:0] waddr_nxt;
    logic              wr_act, wr_last, wr_act_nxt, wr_last_nxt;
    logic              busy_nxt, done_nxt;

    assign start_acc  = (state == IDLE) && fc_start;
    assign issue      = (state == RUN);
    assign last_issue = issue && (i_cnt == I_LAST) && (o_cnt == O_LAST);
    assign tag_in     = issue && (i_cnt == I_LAST);
    assign wo         = o_sr[MAC_LATENCY-1];
    assign wr_bank    = 3'((wo >> 2) % O_W'(5));

    always_ff @(posedge clk) begin
        if (srstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fc_start) state_nxt = RUN;
            RUN:     if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (wr_act && wr_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        i_nxt       = i_cnt;
        o_nxt       = o_cnt;
        w_nxt       = sram_raddr_weight;
        sel_nxt     = data_sel;
        raddr_c_nxt = '0;
        raddr_d_nxt = '0;
        we_nxt      = 5'h1F;
        mask_nxt    = 4'hF;
        waddr_nxt   = sram_waddr_e;
        wr_act_nxt  = 1'b0;
        wr_last_nxt = 1'b0;
        if (start_acc) begin
            i_nxt   = '0;
            o_nxt   = '0;
            w_nxt   = WEIGHT_ADDR_WIDTH'(WEIGHT_BASE);
            sel_nxt = mem_sel;
        end else if (issue) begin
            if (i_cnt == I_LAST) begin
                i_nxt = '0;
                o_nxt = o_cnt + O_W'(1);
            end else begin
                i_nxt = i_cnt + I_W'(1);
            end
            w_nxt = sram_raddr_weight + WEIGHT_ADDR_WIDTH'(1);
        end
        // Only the selected bank set sees the element address; the other stays parked at 0
        if (state_nxt == RUN) begin
            if (sel_nxt) raddr_d_nxt = ADDR_W'(i_nxt);
            else         raddr_c_nxt = ADDR_W'(i_nxt);
        end
        mac_en_nxt    = issue;
        mac_clear_nxt = issue && (i_cnt == '0);
        if (tag_sr[MAC_LATENCY-1]) begin
            we_nxt      = ~(5'(1) << wr_bank);
            mask_nxt    = ~(4'(1) << wo[1:0]);
            waddr_nxt   = ADDR_W'(wo / O_W'(20));
            wr_act_nxt  = 1'b1;
            wr_last_nxt = (wo == O_LAST);
        end
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk) begin
        if (srstn) begin
            i_cnt             <= '0;
            o_cnt             <= '0;
            sram_raddr_c      <= '0;
            sram_raddr_d      <= '0;
            sram_raddr_weight <= '0;
            data_sel          <= 1'b0;
            mac_en            <= 1'b0;
            mac_clear         <= 1'b0;
            we_q              <= 5'h1F;
            sram_bytemask_e   <= 4'hF;
            sram_waddr_e      <= '0;
            wr_act            <= 1'b0;
            wr_last           <= 1'b0;
            busy              <= 1'b0;
            fc_done           <= 1'b0;
            for (int unsigned j = 0; j < MAC_LATENCY; j++) begin
                tag_sr[j] <= 1'b0;
                o_sr[j]   <= '0;
            end
        end else begin
            i_cnt             <= i_nxt;
            o_cnt             <= o_nxt;
            sram_raddr_c      <= raddr_c_nxt;
            sram_raddr_d      <= raddr_d_nxt;
            sram_raddr_weight <= w_nxt;
            data_sel          <= sel_nxt;
            mac_en            <= mac_en_nxt;
            mac_clear         <= mac_clear_nxt;
            we_q              <= we_nxt;
            sram_bytemask_e   <= mask_nxt;
            sram_waddr_e      <= waddr_nxt;
            wr_act            <= wr_act_nxt;
            wr_last           <= wr_last_nxt;
            busy              <= busy_nxt;
            fc_done           <= done_nxt;
            tag_sr[0]         <= tag_in;
            o_sr[0]           <= o_cnt;
            for (int unsigned j = 1; j < MAC_LATENCY; j++) begin
                tag_sr[j] <= tag_sr[j-1];
                o_sr[j]   <= o_sr[j-1];
            end
        end
    end

    // Result is valid in the write cycle itself, so data bypasses the control registers
    assign sram_wdata_e         = wr_act ? fc_result : 8'h00;
    assign sram_write_enable_e0 = we_q[0];
    assign sram_write_enable_e1 = we_q[1];
    assign sram_write_enable_e2 = we_q[2];
    assign sram_write_enable_e3 = we_q[3];
    assign sram_write_enable_e4 = we_q[4];

`ifdef FC_CYCLE_CNT_EN
    always_ff @(posedge clk) begin
        if (srstn)          fc_cycle_cnt <= '0;
        else if (start_acc) fc_cycle_cnt <= '0;
        else if (busy)      fc_cycle_cnt <= fc_cycle_cnt + 20'(1);
    end
`endif

endmodule

// File: tb/tb_fc_ctrl.sv
// Self-checking bench for fc_ctrl: three parameterisations against a cycle-timing reference model.
module tb_fc_ctrl;

    typedef struct packed {
        logic [9:0]  raddr_c;
        logic [9:0]  raddr_d;
        logic [14:0] raddr_w;
        logic        data_sel;
        logic        mac_clear;
        logic        mac_en;
        logic [4:0]  we;
        logic [3:0]  mask;
        logic [9:0]  waddr;
        logic [7:0]  wdata;
        logic        busy;
        logic        done;
    } obs_t;

    typedef struct packed {
        logic iss;
        logic wr;
        obs_t v;
    } exp_t;

    localparam int IN_N  [3] = '{2, 1, 3};
    localparam int OUT_N [3] = '{3, 25, 7};
    localparam int LAT   [3] = '{2, 3, 1};
    localparam int BASE  [3] = '{0, 0, 100};

    logic       clk = 1'b0;
    logic       rst_v   [3];
    logic       start_v [3];
    logic       sel_v   [3];
    logic [7:0] res_v   [3];
    bit         ds_exp  [3];
    wire obs_t  obs0, obs1, obs2;
    int         tests = 0;
    int         fails = 0;

    always #5 clk = ~clk;

`ifdef FC_CYCLE_CNT_EN
    wire [19:0] cnt0, cnt1, cnt2;
`endif

    fc_ctrl #(.WEIGHT_ADDR_WIDTH(15), .IN_ADDR_NUM(IN_N[0]), .OUT_NUM(OUT_N[0]),
              .MAC_LATENCY(LAT[0]), .WEIGHT_BASE(BASE[0])) u0 (
        .clk(clk), .srstn(rst_v[0]), .fc_start(start_v[0]), .mem_sel(sel_v[0]),
        .sram_raddr_c(obs0.raddr_c), .sram_raddr_d(obs0.raddr_d), .sram_raddr_weight(obs0.raddr_w),
        .data_sel(obs0.data_sel), .mac_clear(obs0.mac_clear), .mac_en(obs0.mac_en),
        .fc_result(res_v[0]),
        .sram_write_enable_e0(obs0.we[0]), .sram_write_enable_e1(obs0.we[1]),
        .sram_write_enable_e2(obs0.we[2]), .sram_write_enable_e3(obs0.we[3]),
        .sram_write_enable_e4(obs0.we[4]),
        .sram_bytemask_e(obs0.mask), .sram_waddr_e(obs0.waddr), .sram_wdata_e(obs0.wdata),
        .busy(obs0.busy), .fc_done(obs0.done)
`ifdef FC_CYCLE_CNT_EN
        , .fc_cycle_cnt(cnt0)
`endif
    );

    fc_ctrl #(.WEIGHT_ADDR_WIDTH(15), .IN_ADDR_NUM(IN_N[1]), .OUT_NUM(OUT_N[1]),
              .MAC_LATENCY(LAT[1]), .WEIGHT_BASE(BASE[1])) u1 (
        .clk(clk), .srstn(rst_v[1]), .fc_start(start_v[1]), .mem_sel(sel_v[1]),
        .sram_raddr_c(obs1.raddr_c), .sram_raddr_d(obs1.raddr_d), .sram_raddr_weight(obs1.raddr_w),
        .data_sel(obs1.data_sel), .mac_clear(obs1.mac_clear), .mac_en(obs1.mac_en),
        .fc_result(res_v[1]),
        .sram_write_enable_e0(obs1.we[0]), .sram_write_enable_e1(obs1.we[1]),
        .sram_write_enable_e2(obs1.we[2]), .sram_write_enable_e3(obs1.we[3]),
        .sram_write_enable_e4(obs1.we[4]),
        .sram_bytemask_e(obs1.mask), .sram_waddr_e(obs1.waddr), .sram_wdata_e(obs1.wdata),
        .busy(obs1.busy), .fc_done(obs1.done)
`ifdef FC_CYCLE_CNT_EN
        , .fc_cycle_cnt(cnt1)
`endif
    );

    fc_ctrl #(.WEIGHT_ADDR_WIDTH(15), .IN_ADDR_NUM(IN_N[2]), .OUT_NUM(OUT_N[2]),
              .MAC_LATENCY(LAT[2]), .WEIGHT_BASE(BASE[2])) u2 (
        .clk(clk), .srstn(rst_v[2]), .fc_start(start_v[2]), .mem_sel(sel_v[2]),
        .sram_raddr_c(obs2.raddr_c), .sram_raddr_d(obs2.raddr_d), .sram_raddr_weight(obs2.raddr_w),
        .data_sel(obs2.data_sel), .mac_clear(obs2.mac_clear), .mac_en(obs2.mac_en),
        .fc_result(res_v[2]),
        .sram_write_enable_e0(obs2.we[0]), .sram_write_enable_e1(obs2.we[1]),
        .sram_write_enable_e2(obs2.we[2]), .sram_write_enable_e3(obs2.we[3]),
        .sram_write_enable_e4(obs2.we[4]),
        .sram_bytemask_e(obs2.mask), .sram_waddr_e(obs2.waddr), .sram_wdata_e(obs2.wdata),
        .busy(obs2.busy), .fc_done(obs2.done)
`ifdef FC_CYCLE_CNT_EN
        , .fc_cycle_cnt(cnt2)
`endif
    );

    function automatic obs_t get_obs(input int id);
        case (id)
            0:       return obs0;
            1:       return obs1;
            default: return obs2;
        endcase
    endfunction

`ifdef FC_CYCLE_CNT_EN
    function automatic logic [19:0] get_cnt(input int id);
        case (id)
            0:       return cnt0;
            1:       return cnt1;
            default: return cnt2;
        endcase
    endfunction
`endif

    // Expected outputs in cycle t of a pass whose fc_start was sampled at edge 0
    function automatic exp_t model(input int id, input int t, input bit s, input logic [7:0] res);
        exp_t e;
        int   n, k, m, o;
        n = IN_N[id] * OUT_N[id];
        e = '0;
        e.v.we   = 5'h1F;
        e.v.mask = 4'hF;
        if (t >= 1 && t <= n) begin
            k = t - 1;
            e.iss = 1'b1;
            if (s) e.v.raddr_d = 10'(k % IN_N[id]);
            else   e.v.raddr_c = 10'(k % IN_N[id]);
            e.v.raddr_w = 15'(BASE[id] + k);
        end
        if (t >= 2 && t <= n + 1) begin
            e.v.mac_en    = 1'b1;
            e.v.mac_clear = ((t - 2) % IN_N[id]) == 0;
        end
        m = t - 1 - LAT[id];
        if (m >= IN_N[id] && (m % IN_N[id]) == 0 && (m / IN_N[id]) <= OUT_N[id]) begin
            o = m / IN_N[id] - 1;
            e.wr      = 1'b1;
            e.v.we    = ~(5'(1) << ((o / 4) % 5));
            e.v.mask  = ~(4'(1) << (o % 4));
            e.v.waddr = 10'(o / 20);
            e.v.wdata = res;
        end
        e.v.busy = (t >= 1) && (t <= n + 2 + LAT[id]);
        e.v.done = (t == n + 2 + LAT[id]);
        return e;
    endfunction

    task automatic chk(input string tag, input int id, input int t,
                       input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s dut%0d cycle %0d: got %0h expected %0h", tag, id, t, got, exp);
        end
    endtask

    task automatic compare(input int id, input int t, input bit s, input bit all_addr);
        obs_t g;
        exp_t e;
        g = get_obs(id);
        e = model(id, t, s, res_v[id]);
        if (s) begin
            chk("raddr_c_unsel", id, t, 32'(g.raddr_c), 32'(0));
            if (e.iss || all_addr) chk("raddr_d", id, t, 32'(g.raddr_d), 32'(e.v.raddr_d));
        end else begin
            chk("raddr_d_unsel", id, t, 32'(g.raddr_d), 32'(0));
            if (e.iss || all_addr) chk("raddr_c", id, t, 32'(g.raddr_c), 32'(e.v.raddr_c));
        end
        if (e.iss || all_addr) chk("raddr_w", id, t, 32'(g.raddr_w), 32'(e.v.raddr_w));
        chk("data_sel",  id, t, 32'(g.data_sel),  32'(ds_exp[id]));
        chk("mac_en",    id, t, 32'(g.mac_en),    32'(e.v.mac_en));
        chk("mac_clear", id, t, 32'(g.mac_clear), 32'(e.v.mac_clear));
        chk("we",        id, t, 32'(g.we),        32'(e.v.we));
        chk("mask",      id, t, 32'(g.mask),      32'(e.v.mask));
        chk("wdata",     id, t, 32'(g.wdata),     32'(e.v.wdata));
        if (e.wr || all_addr) chk("waddr", id, t, 32'(g.waddr), 32'(e.v.waddr));
        chk("busy",      id, t, 32'(g.busy),      32'(e.v.busy));
        chk("done",      id, t, 32'(g.done),      32'(e.v.done));
    endtask

    task automatic run_pass(input int id, input bit s, input int abort_t, input bit repulse);
        int n, tot, done_t;
        n      = IN_N[id] * OUT_N[id];
        done_t = n + 2 + LAT[id];
        tot    = done_t + 5;
        @(negedge clk);
        start_v[id] = 1'b1;
        sel_v[id]   = s;
        res_v[id]   = 8'($urandom);
        for (int t = 1; t <= tot; t++) begin
            @(negedge clk);
            if (t == 1) ds_exp[id] = s;
            if (abort_t > 0 && t > abort_t) begin
                ds_exp[id] = 1'b0;
                compare(id, -1, s, 1'b1);
            end else begin
                compare(id, t, s, 1'b0);
`ifdef FC_CYCLE_CNT_EN
                chk("cycle_cnt", id, t, 32'(get_cnt(id)), 32'((t - 1 < done_t) ? t - 1 : done_t));
`endif
            end
            start_v[id] = repulse && (t == 3 || t == done_t);
            if (repulse && t == done_t) sel_v[id] = ~s;
            rst_v[id] = (abort_t > 0 && t == abort_t);
            res_v[id] = 8'($urandom);
        end
    endtask

    initial begin
        bit s_prev;
        for (int i = 0; i < 3; i++) begin
            rst_v[i]   = 1'b1;
            start_v[i] = 1'b0;
            sel_v[i]   = 1'b0;
            res_v[i]   = 8'($urandom);
            ds_exp[i]  = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) compare(i, -1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;
        @(negedge clk);

        run_pass(0, 1'b0, 0, 1'b0);
        run_pass(0, 1'b1, 0, 1'b0);
        run_pass(0, 1'b0, 0, 1'b1);
        run_pass(0, 1'b1, 4, 1'b0);
        run_pass(0, 1'b0, 0, 1'b0);

        run_pass(1, 1'b0, 0, 1'b0);
        run_pass(1, 1'b1, 0, 1'b0);

        s_prev = 1'b0;
        for (int p = 0; p < 5; p++) begin
            int gap;
            bit s;
            gap = int'($urandom_range(3, 0));
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                compare(2, 1 << 20, s_prev, 1'b0);
                res_v[2] = 8'($urandom);
            end
            s = 1'($urandom);
            run_pass(2, s, 0, 1'($urandom));
            s_prev = s;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
